// File: rtl/udp_uart_bridge_tx.sv
// Byte-stream to 8N1 UART bridge: a block-RAM FIFO with a prefetched head byte
// feeds a start/data/stop serialiser; bytes arriving while the FIFO is full are dropped.
module udp_uart_bridge_tx #(
  parameter int CLKS_PER_BIT   = 868,
  parameter int FIFO_ADDR_BITS = 11
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    data_in_en,
  input  logic [7:0]              data_in,
  input  logic                    overflow_clr,
  output logic                    uart_tx,
  output logic [FIFO_ADDR_BITS:0] fifo_count,
  output logic                    overflow,
  output logic                    busy
);

  localparam int DEPTH     = 1 << FIFO_ADDR_BITS;
  localparam int BAUD_BITS = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_BITS-1:0]      BAUD_LAST = BAUD_BITS'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_BITS-1:0]      BAUD_ONE  = BAUD_BITS'(1);
  localparam logic [FIFO_ADDR_BITS-1:0] PTR_ONE   = FIFO_ADDR_BITS'(1);
  localparam logic [FIFO_ADDR_BITS:0]   CNT_ONE   = (FIFO_ADDR_BITS + 1)'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                    state, state_next;
  logic [BAUD_BITS-1:0]      baud_cnt, baud_cnt_next;
  logic [2:0]                bit_idx, bit_idx_next;
  logic [8:0]                shreg, shreg_next;
  logic                      uart_tx_next;
  logic                      pop;

  logic [7:0]                mem [DEPTH];
  logic [7:0]                head;
  logic [FIFO_ADDR_BITS-1:0] wr_ptr, rd_ptr, rd_addr;
  logic                      fifo_full, fifo_empty, wr_en, drop, baud_done;

  // The count can never exceed DEPTH, so its MSB alone marks a full FIFO.
  assign fifo_full  = fifo_count[FIFO_ADDR_BITS];
  assign fifo_empty = (fifo_count == '0);
  assign wr_en      = data_in_en && !fifo_full;
  assign drop       = data_in_en && fifo_full;
  assign rd_addr    = pop ? rd_ptr + PTR_ONE : rd_ptr;
  assign baud_done  = (baud_cnt == BAUD_LAST);
  assign busy       = (state != IDLE) || !fifo_empty;

  // Head register always holds the byte at the post-edge read pointer; a write to
  // that same address bypasses the RAM so a freshly stored byte can pop next cycle.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= data_in;
    head <= (wr_en && (wr_ptr == rd_addr)) ? data_in : mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: fifo_count <= fifo_count;
      endcase
      if (drop)
        overflow <= 1'b1;
      else if (overflow_clr)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '1;
      uart_tx  <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_cnt_next;
      bit_idx  <= bit_idx_next;
      shreg    <= shreg_next;
      uart_tx  <= uart_tx_next;
    end
  end

  // Shift register is loaded as {stop, data}; each bit boundary emits bit 0 and
  // shifts, so the ninth shift naturally yields the stop level.
  always_comb begin
    state_next    = state;
    baud_cnt_next = baud_cnt + BAUD_ONE;
    bit_idx_next  = bit_idx;
    shreg_next    = shreg;
    uart_tx_next  = uart_tx;
    pop           = 1'b0;
    case (state)
      IDLE: begin
        baud_cnt_next = '0;
        uart_tx_next  = 1'b1;
        if (!fifo_empty) begin
          pop          = 1'b1;
          shreg_next   = {1'b1, head};
          uart_tx_next = 1'b0;
          state_next   = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_cnt_next = '0;
          bit_idx_next  = '0;
          uart_tx_next  = shreg[0];
          shreg_next    = {1'b1, shreg[8:1]};
          state_next    = DATA;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_cnt_next = '0;
          uart_tx_next  = shreg[0];
          shreg_next    = {1'b1, shreg[8:1]};
          if (bit_idx == 3'd7)
            state_next = STOP;
          else
            bit_idx_next = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_cnt_next = '0;
          if (!fifo_empty) begin
            pop          = 1'b1;
            shreg_next   = {1'b1, head};
            uart_tx_next = 1'b0;
            state_next   = START;
          end else begin
            uart_tx_next = 1'b1;
            state_next   = IDLE;
          end
        end
      end
      default: begin
        state_next   = IDLE;
        uart_tx_next = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_udp_uart_bridge_tx.sv
// Testbench for udp_uart_bridge_tx: table vectors, hand-written frame sequences and
// randomized traffic checked against a frame-position reference model.
module tb_udp_uart_bridge_tx;

  localparam int CPB   = 4;
  localparam int FAB   = 2;
  localparam int DEPTH = 1 << FAB;
  localparam int FRAME = 10 * CPB;

  logic         clk;
  logic         reset;
  logic         data_in_en;
  logic [7:0]   data_in;
  logic         overflow_clr;
  logic         uart_tx;
  logic [FAB:0] fifo_count;
  logic         overflow;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int peak_count = 0;
  bit model_on = 0;
  logic tx_log[$];

  // Reference model: queued bytes plus position within the current 10-bit frame.
  logic [7:0] mq[$];
  bit         m_active = 0;
  int         m_pos = 0;
  logic [7:0] m_byte = '0;
  bit         m_ovf = 0;

  typedef struct {
    logic       en;
    logic [7:0] din;
    logic       clr;
    int         exp_count;
    logic       exp_ovf;
    logic       exp_busy;
    logic       exp_tx;
  } vec_t;

  vec_t vecs[9];

  udp_uart_bridge_tx #(.CLKS_PER_BIT(CPB), .FIFO_ADDR_BITS(FAB)) dut (
    .clk(clk),
    .reset(reset),
    .data_in_en(data_in_en),
    .data_in(data_in),
    .overflow_clr(overflow_clr),
    .uart_tx(uart_tx),
    .fifo_count(fifo_count),
    .overflow(overflow),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic model_tx();
    if (!m_active) return 1'b1;
    if (m_pos < CPB) return 1'b0;
    if (m_pos < 9 * CPB) return m_byte[(m_pos - CPB) / CPB];
    return 1'b1;
  endfunction

  function automatic void model_step(input logic en, input logic [7:0] din,
                                     input logic clr, input logic rst);
    int size_before;
    bit do_pop;
    if (rst) begin
      mq.delete();
      m_active = 0;
      m_pos = 0;
      m_ovf = 0;
      return;
    end
    size_before = mq.size();
    do_pop = (size_before != 0) && (!m_active || m_pos == FRAME - 1);
    if (m_active) begin
      if (m_pos == FRAME - 1) m_active = 0;
      else m_pos++;
    end
    if (do_pop) begin
      m_byte = mq.pop_front();
      m_active = 1;
      m_pos = 0;
    end
    if (en && size_before < DEPTH) mq.push_back(din);
    if (en && size_before == DEPTH) m_ovf = 1;
    else if (clr) m_ovf = 0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [7:0] din,
                               input logic clr, input logic rst);
    data_in_en   = en;
    data_in      = din;
    overflow_clr = clr;
    reset        = rst;
    @(posedge clk);
    model_step(en, din, clr, rst);
    #1;
    tx_log.push_back(uart_tx);
    if (int'(fifo_count) > peak_count) peak_count = int'(fifo_count);
    if (model_on) begin
      checkOutput("model_tx", 32'(uart_tx), 32'(model_tx()));
      checkOutput("model_count", 32'(fifo_count), 32'(mq.size()));
      checkOutput("model_overflow", 32'(overflow), 32'(m_ovf));
      checkOutput("model_busy", 32'(busy), 32'(m_active || mq.size() != 0));
    end
  endtask

  task automatic idle_until(input int log_size);
    while (tx_log.size() < log_size) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // Decodes one frame from the logged line starting at a falling edge.
  task automatic check_frame(input int start, input logic [7:0] exp_byte, input string name);
    logic [7:0] b;
    logic       lvl;
    bit         clean;
    clean = 1;
    b = '0;
    if (start + FRAME > tx_log.size()) clean = 0;
    else begin
      if (start > 0 && tx_log[start-1] !== 1'b1) clean = 0;
      for (int k = 0; k < 10; k++) begin
        lvl = tx_log[start + k*CPB];
        for (int s = 0; s < CPB; s++)
          if (tx_log[start + k*CPB + s] !== lvl) clean = 0;
        if (k == 0 && lvl !== 1'b0) clean = 0;
        if (k == 9 && lvl !== 1'b1) clean = 0;
        if (k >= 1 && k <= 8) b[k-1] = lvl;
      end
    end
    checkOutput(name, {23'd0, clean, b}, {23'd0, 1'b1, exp_byte});
  endtask

  initial begin
    logic [4:0] tail;
    int cycles;
    int burst;

    vecs[0] = '{1'b1, 8'h10, 1'b0, 1, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 8'h11, 1'b0, 1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 8'h12, 1'b0, 2, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 8'h13, 1'b0, 3, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 8'h14, 1'b0, 4, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 8'h15, 1'b0, 4, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 4, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 8'h16, 1'b1, 4, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 8'h00, 1'b0, 4, 1'b1, 1'b1, 1'b0};

    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("reset_tx", 32'(uart_tx), 32'd1);
    checkOutput("reset_count", 32'(fifo_count), 32'd0);
    checkOutput("reset_overflow", 32'(overflow), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    $display("[TB] single byte 0x55");
    tx_log.delete();
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
    checkOutput("single_count_after_strobe", 32'(fifo_count), 32'd1);
    checkOutput("single_tx_after_strobe", 32'(uart_tx), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("single_tx_start", 32'(uart_tx), 32'd0);
    checkOutput("single_count_after_pop", 32'(fifo_count), 32'd0);
    checkOutput("single_busy_start", 32'(busy), 32'd1);
    idle_until(41);
    checkOutput("single_busy_last_stop", 32'(busy), 32'd1);
    idle_until(42);
    checkOutput("single_busy_end", 32'(busy), 32'd0);
    checkOutput("single_tx_end", 32'(uart_tx), 32'd1);
    check_frame(1, 8'h55, "single_frame");

    $display("[TB] burst 0x01 0x80 0xFF");
    tx_log.delete();
    peak_count = 0;
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h80, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
    checkOutput("burst_count", 32'(fifo_count), 32'd2);
    idle_until(122);
    checkOutput("burst_peak", 32'(peak_count), 32'd2);
    checkOutput("burst_no_early_start", 32'(tx_log[0]), 32'd1);
    check_frame(1, 8'h01, "burst_frame0");
    check_frame(41, 8'h80, "burst_frame1");
    check_frame(81, 8'hFF, "burst_frame2");
    checkOutput("burst_busy_end", 32'(busy), 32'd0);

    $display("[TB] overflow table");
    tx_log.delete();
    peak_count = 0;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].en, vecs[i].din, vecs[i].clr, 1'b0);
      checkOutput($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vecs[i].exp_count));
      checkOutput($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].exp_ovf));
      checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      checkOutput($sformatf("vec%0d_tx", i), 32'(uart_tx), 32'(vecs[i].exp_tx));
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("clr_no_drop", 32'(overflow), 32'd0);
    idle_until(41);
    checkOutput("full_before_pop_count", 32'(fifo_count), 32'd4);
    checkOutput("full_before_pop_overflow", 32'(overflow), 32'd0);
    checkOutput("full_before_pop_tx", 32'(uart_tx), 32'd1);
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);
    checkOutput("pop_and_drop_count", 32'(fifo_count), 32'd3);
    checkOutput("pop_and_drop_overflow", 32'(overflow), 32'd1);
    checkOutput("pop_and_drop_tx", 32'(uart_tx), 32'd0);
    idle_until(206);
    check_frame(1, 8'h10, "ovf_frame0");
    check_frame(41, 8'h11, "ovf_frame1");
    check_frame(81, 8'h12, "ovf_frame2");
    check_frame(121, 8'h13, "ovf_frame3");
    check_frame(161, 8'h14, "ovf_frame4");
    for (int i = 0; i < 5; i++) tail[i] = tx_log[201 + i];
    checkOutput("ovf_idle_tail", 32'(tail), 32'h1F);
    checkOutput("ovf_peak", 32'(peak_count), 32'd4);
    checkOutput("ovf_busy_end", 32'(busy), 32'd0);

    $display("[TB] reset mid-frame");
    tx_log.delete();
    applyStimulus(1'b1, 8'hA1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hB2, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0);
    idle_until(19);
    checkOutput("pre_reset_count", 32'(fifo_count), 32'd2);
    checkOutput("pre_reset_overflow", 32'(overflow), 32'd1);
    checkOutput("pre_reset_tx_bit3", 32'(uart_tx), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("midreset_tx", 32'(uart_tx), 32'd1);
    checkOutput("midreset_count", 32'(fifo_count), 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_overflow", 32'(overflow), 32'd0);
    tx_log.delete();
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
    idle_until(45);
    check_frame(1, 8'hA5, "post_reset_frame");
    checkOutput("post_reset_busy_end", 32'(busy), 32'd0);

    $display("[TB] randomized traffic against model");
    model_on = 1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    burst = 0;
    cycles = 0;
    while (cycles < 3000) begin
      logic en;
      if (burst == 0 && $urandom_range(0, 199) == 0) burst = $urandom_range(3, 8);
      en = (burst > 0) || ($urandom_range(0, 99) < 2);
      if (burst > 0) burst--;
      applyStimulus(en, 8'($urandom_range(0, 255)), $urandom_range(0, 63) == 0,
                    $urandom_range(0, 1499) == 0);
      cycles++;
    end
    for (int i = 0; i < 300; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    model_on = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/udp_uart_bridge_tx.md
# udp_uart_bridge_tx

Downstream stage of the UDP packet receiver. Accepts the receiver's byte stream (a strobe plus a byte, with no backpressure), buffers it in a byte FIFO, and serialises it onto an 8N1 UART transmit line. Packet payload bursts arrive far faster than the UART drains them, so the FIFO absorbs them. On overflow, excess bytes are dropped and a sticky flag is set.

## Interface
Parameters:
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200). Legal range ≥ 2.
- FIFO_ADDR_BITS, 11: FIFO depth is 2^FIFO_ADDR_BITS bytes.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- data_in_en  in  1  byte strobe from the packet receiver, one byte per asserted cycle
- data_in  in  8  payload byte, valid when data_in_en = 1
- overflow_clr  in  1  clears the sticky overflow flag
- uart_tx  out  1  serial output, idle high, registered
- fifo_count  out  FIFO_ADDR_BITS+1  bytes currently held, registered
- overflow  out  1  sticky: one or more bytes dropped
- busy  out  1  high while a frame is in progress or fifo_count ≠ 0

Reset and clock: reset is synchronous and active-high; the clock is clk.

## Operation
- Reset values: uart_tx = 1, fifo_count = 0, overflow = 0, busy = 0, FSM = IDLE. The read pointer, write pointer and counters are zeroed. FIFO contents are don't-care.
- Write: when data_in_en = 1 and fifo_count < 2^FIFO_ADDR_BITS (evaluated before the edge), data_in is written at the write pointer and the pointer increments modulo the depth.
- Full: when data_in_en = 1 and the FIFO is full, the byte is discarded and overflow is set at the edge. This applies even if a pop happens in the same cycle.
- overflow_clr clears overflow. If a drop occurs in the same cycle, set wins.
- Pop: takes the head byte into a 9-bit shift register and advances the read pointer modulo the depth.
- Simultaneous write and pop: fifo_count is unchanged.
- The FIFO is inferred as block RAM. A read-ahead/prefetch register makes the head byte available at pop time with no extra cycle.
- FSM states:
  - IDLE: uart_tx = 1. If fifo_count ≠ 0, pop, drive uart_tx = 0, and go to START.
  - START: hold uart_tx = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: output shift-register bits LSB first, each for CLKS_PER_BIT cycles. After bit 7, drive uart_tx = 1 and go to STOP.
  - STOP: hold uart_tx = 1 for CLKS_PER_BIT cycles. At the end, if fifo_count ≠ 0, pop, drive uart_tx = 0 and go to START directly; otherwise go to IDLE.
- Baud counter: runs 0 to CLKS_PER_BIT−1 and reloads on each bit transition. Its width is clog2(CLKS_PER_BIT). The bit index is 3 bits.
- Reset mid-frame: uart_tx = 1 from the next edge. The FIFO is flushed (count 0) and the partial frame is abandoned. overflow is cleared.

## Timing
- Byte strobed at edge E into an empty FIFO with the FSM in IDLE:
  - fifo_count = 1 after E.
  - The pop happens at E+1: uart_tx falls and fifo_count returns to 0 after E+1.
- Frame length is exactly 10·CLKS_PER_BIT cycles: start, 8 data bits, stop.
- Back-to-back frames have no idle gap. The next start edge occurs exactly 10·CLKS_PER_BIT cycles after the previous one.
- The last frame ends with STOP followed by IDLE. busy falls on the edge at which IDLE is entered with fifo_count = 0.
- There is no backpressure path to the receiver. The only consequence of data loss is overflow.

## Test plan
- Single byte (CLKS_PER_BIT = 4): strobe 0x55 once → uart_tx = 0 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then 1. Total 40 cycles from the falling edge. busy deasserts afterwards.
- Burst (CLKS_PER_BIT = 4): strobe 0x01, 0x80, 0xFF on consecutive cycles → fifo_count peaks at 2. Three frames are decoded in order with falling start edges 40 cycles apart and no idle gaps.
- Overflow (FIFO_ADDR_BITS = 2): strobe 0x10..0x15 on 6 consecutive cycles while idle → 0x10 pops at the second edge. 0x10..0x14 are sent and 0x15 is dropped. overflow = 1 after the edge sampling 0x15. fifo_count never exceeds 4.
- Simultaneous write/pop (FIFO_ADDR_BITS = 2): with the FIFO full, strobe a byte on the STOP→START pop cycle → the byte is dropped, overflow is set, and fifo_count goes from 4 to 3.
- overflow_clr: assert for one cycle with no drop → overflow = 0. Assert in the same cycle as a drop → overflow stays 1.
- Reset mid-frame: assert reset during DATA bit 3 with 2 bytes queued → next edge: uart_tx = 1, fifo_count = 0, busy = 0, overflow = 0. A fresh strobe of 0xA5 afterwards transmits correctly.
